// File: rtl/wb_reg_file_pkg.sv
// Shared MEM/WB pipeline constants and the write-back bundle layout.
// The MEM stage register packs the bundle with these same offsets.
package wb_reg_file_pkg;
  localparam int XLEN        = 32;
  localparam int NREGS       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int WB_BUNDLE_W = 38;
  localparam int WB_EN_BIT   = 37;
  localparam int WB_ADDR_HI  = 36;
  localparam int WB_ADDR_LO  = 32;
  localparam int WB_DATA_HI  = 31;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_bundle_t;

  function automatic wb_bundle_t unpack_wb(input logic [WB_BUNDLE_W-1:0] v);
    wb_bundle_t b;
    b.en   = v[WB_EN_BIT];
    b.addr = v[WB_ADDR_HI:WB_ADDR_LO];
    b.data = v[WB_DATA_HI:0];
    return b;
  endfunction
endpackage

// File: rtl/wb_reg_file_if.sv
// Write-back bundle in, decode-stage read ports and retire status out.
interface wb_reg_file_if;
  import wb_reg_file_pkg::*;

  logic [WB_BUNDLE_W-1:0] wb_bundle;
  logic                   mem_busywait;
  logic [REG_ADDR_W-1:0]  rs1_addr;
  logic [REG_ADDR_W-1:0]  rs2_addr;
  logic [XLEN-1:0]        rs1_data;
  logic [XLEN-1:0]        rs2_data;
  logic                   wb_retired;
  logic [XLEN-1:0]        wb_count;

  modport master (
    output wb_bundle, mem_busywait, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_retired, wb_count
  );

  modport slave (
    input  wb_bundle, mem_busywait, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_retired, wb_count
  );
endinterface

// File: rtl/wb_reg_file_reg_array.sv
// NREGS x XLEN storage: one synchronous write port, two asynchronous read
// ports, synchronous clear of every entry.
module wb_reg_file_reg_array
  import wb_reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic [XLEN-1:0]       o_rdata1,
  output logic [XLEN-1:0]       o_rdata2
);
  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];
endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage: retires the MEM/WB bundle into the integer register file
// and serves the decode-stage read ports with same-cycle bypass.
module wb_reg_file
  import wb_reg_file_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  wb_reg_file_if.slave  wb_if
);
  wb_bundle_t      w_bundle;
  logic            w_commit;
  logic [XLEN-1:0] w_arr_rd1;
  logic [XLEN-1:0] w_arr_rd2;
  logic            r_wb_retired;
  logic [XLEN-1:0] r_wb_count;

  assign w_bundle = unpack_wb(wb_if.wb_bundle);

  // Reset and stall both invalidate the bundle, which also kills the bypass.
  assign w_commit = w_bundle.en & ~wb_if.mem_busywait &
                    (w_bundle.addr != '0) & ~reset;

  wb_reg_file_reg_array u_reg_array (
    .clk      (clk),
    .i_clr    (reset),
    .i_we     (w_commit),
    .i_waddr  (w_bundle.addr),
    .i_wdata  (w_bundle.data),
    .i_raddr1 (wb_if.rs1_addr),
    .i_raddr2 (wb_if.rs2_addr),
    .o_rdata1 (w_arr_rd1),
    .o_rdata2 (w_arr_rd2)
  );

  always_comb begin
    wb_if.rs1_data = w_arr_rd1;
    if (wb_if.rs1_addr == '0)
      wb_if.rs1_data = '0;
    else if (w_commit && (wb_if.rs1_addr == w_bundle.addr))
      wb_if.rs1_data = w_bundle.data;
  end

  always_comb begin
    wb_if.rs2_data = w_arr_rd2;
    if (wb_if.rs2_addr == '0)
      wb_if.rs2_data = '0;
    else if (w_commit && (wb_if.rs2_addr == w_bundle.addr))
      wb_if.rs2_data = w_bundle.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_retired <= 1'b0;
      r_wb_count   <= '0;
    end else begin
      r_wb_retired <= w_commit;
      if (w_commit) r_wb_count <= r_wb_count + 1'b1;
    end
  end

  assign wb_if.wb_retired = r_wb_retired;
  assign wb_if.wb_count   = r_wb_count;
endmodule
